// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: a small instruction FIFO feeding a registered issue
// slot, with a two-deep RAW hazard window, a flush/drain sequence and counters.
module pipe_issue_ctrl #(
  parameter int QDEPTH     = 4,
  parameter int PIPE_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_func,
  input  logic [7:0]  in_addr,
  input  logic        flush,
  output logic        iss_valid,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        busy,
  output logic        drain_done,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int DW = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;
  localparam int EW = 24;

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   q_mem [QDEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   q_cnt;
  logic            vld_p0, vld_p1;
  logic [3:0]      rd_p0, rd_p1;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic            drain_fire;

  logic [3:0]      h_rs1, h_rs2, h_rd, h_func;
  logic [7:0]      h_addr;
  logic            q_nempty, q_full, hit_p0, hit_p1, hazard, issue, enq;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign {h_rs1, h_rs2, h_rd, h_func, h_addr} = q_mem[rd_ptr];

  assign q_nempty = (q_cnt != '0);
  assign q_full   = (q_cnt == CW'(QDEPTH));
  assign hit_p0   = vld_p0 && ((h_rs1 == rd_p0) || (h_rs2 == rd_p0));
  assign hit_p1   = vld_p1 && ((h_rs1 == rd_p1) || (h_rs2 == rd_p1));
  // Issue is decided purely by the head and the window; the FSM only tracks phase.
  assign hazard   = q_nempty && (hit_p0 || hit_p1);
  assign issue    = q_nempty && !(hit_p0 || hit_p1);
  assign in_ready = !q_full && (state != DRAIN);
  assign enq      = in_valid && in_ready;
  assign busy     = q_nempty || vld_p0 || vld_p1 || (state == DRAIN);

  always_comb begin
    state_nxt  = state;
    dcnt_nxt   = dcnt;
    drain_fire = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else if (q_nempty) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else if (hazard) begin
          state_nxt = STALL;
        end else if (!q_nempty) begin
          state_nxt = IDLE;
        end
      end
      STALL: begin
        if (flush) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else if (!hazard) begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        // The countdown only advances once the queue has fully issued.
        if (!q_nempty) begin
          if (dcnt == DW'(PIPE_DEPTH)) begin
            drain_fire = 1'b1;
            state_nxt  = IDLE;
            dcnt_nxt   = '0;
          end else begin
            dcnt_nxt = dcnt + DW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: issue slot and hazard window head; p1: second window slot
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      dcnt       <= '0;
      drain_done <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      q_cnt      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      iss_valid  <= 1'b0;
      rs1        <= '0;
      rs2        <= '0;
      rd         <= '0;
      func       <= '0;
      addr       <= '0;
      issue_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      dcnt       <= dcnt_nxt;
      drain_done <= drain_fire;
      if (enq)   wr_ptr <= ptr_inc(wr_ptr);
      if (issue) rd_ptr <= ptr_inc(rd_ptr);
      q_cnt      <= q_cnt + CW'(enq) - CW'(issue);
      vld_p0     <= issue;
      vld_p1     <= vld_p0;
      iss_valid  <= issue;
      rs1        <= issue ? h_rs1  : '0;
      rs2        <= issue ? h_rs2  : '0;
      rd         <= issue ? h_rd   : '0;
      func       <= issue ? h_func : '0;
      addr       <= issue ? h_addr : '0;
      if (issue)  issue_cnt <= sat_inc(issue_cnt);
      if (hazard) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Data-only storage: qualified by pointers and window valids, so no reset.
  always_ff @(posedge CLK) begin
    if (enq) q_mem[wr_ptr] <= {in_rs1, in_rs2, in_rd, in_func, in_addr};
    rd_p0 <= issue ? h_rd : '0;
    rd_p1 <= rd_p0;
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Scoreboard bench for pipe_issue_ctrl: a queue/history reference model predicts
// each issue and drain_done edge; a monitor process checks the DUT against it.
module tb_pipe_issue_ctrl;

  localparam int QDEPTH     = 4;
  localparam int PIPE_DEPTH = 4;

  logic        CLK, RST_N;
  logic        in_valid, in_ready, flush;
  logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
  logic [7:0]  in_addr;
  logic        iss_valid, busy, drain_done;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic [15:0] issue_cnt, stall_cnt;

  pipe_issue_ctrl #(.QDEPTH(QDEPTH), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
    .in_addr(in_addr), .flush(flush), .iss_valid(iss_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .busy(busy), .drain_done(drain_done),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] rs1, rs2, rd, func;
    logic [7:0] addr;
  } ins_t;
  typedef struct { int edge_n; ins_t ins; } exp_t;
  typedef struct { int edge_n; logic [3:0] rd; } hrec_t;

  int    checks = 0, failures = 0;
  int    edge_no = 0;
  ins_t  mq[$];
  hrec_t hist[$];
  exp_t  sb[$];
  int    dd_q[$];
  int    iss_log[$];
  int    dd_log[$];
  int    m_icnt, m_scnt, m_dcnt;
  bit    m_drain;
  bit    saw_not_ready;
  bit    acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic ins_t mk(input int a, input int b, input int c, input int f, input int ad);
    ins_t r;
    r.rs1 = 4'(a); r.rs2 = 4'(b); r.rd = 4'(c); r.func = 4'(f); r.addr = 8'(ad);
    return r;
  endfunction

  // Monitor: compares what the DUT presents against the scoreboard queues.
  always @(posedge CLK) begin
    bit   exp_v, exp_d;
    exp_t e;
    edge_no = edge_no + 1;
    #1;
    exp_v = (sb.size() > 0) && (sb[0].edge_n == edge_no);
    chk("iss_valid", 32'(iss_valid), 32'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      chk("iss_fields", {8'h0, rs1, rs2, rd, func, addr}, {8'h0, e.ins});
      iss_log.push_back(edge_no);
    end else begin
      chk("idle_fields", {8'h0, rs1, rs2, rd, func, addr}, 32'h0);
    end
    while (sb.size() > 0 && sb[0].edge_n <= edge_no) void'(sb.pop_front());
    exp_d = (dd_q.size() > 0) && (dd_q[0] == edge_no);
    chk("drain_done", 32'(drain_done), 32'(exp_d));
    if (exp_d) dd_log.push_back(edge_no);
    while (dd_q.size() > 0 && dd_q[0] <= edge_no) void'(dd_q.pop_front());
  end

  // Drive one cycle from a falling edge; the model predicts the next rising edge.
  task automatic step(input bit v, input ins_t ins, input bit fl, output bit accepted);
    int  n;
    bit  haz, iss, rdy, enq, m_busy;
    exp_t e;
    hrec_t h;
    in_valid = v;
    in_rs1 = ins.rs1; in_rs2 = ins.rs2; in_rd = ins.rd; in_func = ins.func; in_addr = ins.addr;
    flush = fl;
    #1;
    n = edge_no + 1;
    rdy = (mq.size() < QDEPTH) && !m_drain;
    m_busy = (mq.size() != 0) || m_drain;
    foreach (hist[i]) if (hist[i].edge_n == n - 1 || hist[i].edge_n == n - 2) m_busy = 1'b1;
    if (!in_ready) saw_not_ready = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("issue_cnt", 32'(issue_cnt), 32'(m_icnt));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    haz = 1'b0;
    if (mq.size() > 0)
      foreach (hist[i])
        if ((hist[i].edge_n == n - 1 || hist[i].edge_n == n - 2) &&
            (hist[i].rd == mq[0].rs1 || hist[i].rd == mq[0].rs2)) haz = 1'b1;
    iss = (mq.size() > 0) && !haz;
    enq = v && rdy;
    if (m_drain) begin
      if (mq.size() == 0) begin
        m_dcnt++;
        if (m_dcnt == PIPE_DEPTH + 1) begin
          dd_q.push_back(n);
          m_drain = 1'b0;
        end
      end
    end else if (fl) begin
      m_drain = 1'b1;
      m_dcnt  = 0;
    end
    if (haz && m_scnt < 65535) m_scnt++;
    if (iss) begin
      e.edge_n = n; e.ins = mq.pop_front();
      sb.push_back(e);
      h.edge_n = n; h.rd = e.ins.rd;
      hist.push_back(h);
      if (m_icnt < 65535) m_icnt++;
    end
    if (enq) mq.push_back(ins);
    while (hist.size() > 0 && hist[0].edge_n < n - 1) void'(hist.pop_front());
    accepted = enq;
    @(negedge CLK);
  endtask

  task automatic idle(input int cycles);
    bit a;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0, a);
  endtask

  task automatic push_ins(input ins_t ins);
    bit a;
    step(1'b1, ins, 1'b0, a);
  endtask

  // Assert reset between edges, check the reset values, then release on a falling edge.
  task automatic apply_reset();
    in_valid = 1'b0; flush = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("rst_iss_valid", 32'(iss_valid), 32'h0);
    chk("rst_fields", {8'h0, rs1, rs2, rd, func, addr}, 32'h0);
    chk("rst_drain_done", 32'(drain_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    mq.delete(); hist.delete(); sb.delete(); dd_q.delete();
    iss_log.delete(); dd_log.delete();
    m_icnt = 0; m_scnt = 0; m_dcnt = 0; m_drain = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int f_edge, guard;
    RST_N = 1'b1; in_valid = 1'b0; flush = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_func = '0; in_addr = '0;
    #1 RST_N = 1'b0;
    @(negedge CLK);
    apply_reset();

    // Independent stream
    push_ins(mk(3, 5, 10, 1, 8'h10));
    push_ins(mk(1, 2, 2, 2, 8'h11));
    push_ins(mk(15, 14, 4, 3, 8'h12));
    idle(4);
    chk("indep_issue_cnt", 32'(issue_cnt), 32'd3);
    chk("indep_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("indep_n_issued", 32'(iss_log.size()), 32'd3);
    if (iss_log.size() == 3) chk("indep_consecutive", 32'(iss_log[2] - iss_log[0]), 32'd2);

    // RAW distance 1
    apply_reset();
    push_ins(mk(5, 3, 1, 0, 8'h20));
    push_ins(mk(1, 2, 2, 0, 8'h21));
    idle(6);
    chk("raw1_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("raw1_n_issued", 32'(iss_log.size()), 32'd2);
    if (iss_log.size() == 2) chk("raw1_gap", 32'(iss_log[1] - iss_log[0]), 32'd3);

    // RAW distance 2
    apply_reset();
    push_ins(mk(5, 3, 1, 0, 8'h30));
    push_ins(mk(15, 14, 4, 0, 8'h31));
    push_ins(mk(1, 13, 5, 0, 8'h32));
    idle(6);
    chk("raw2_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("raw2_n_issued", 32'(iss_log.size()), 32'd3);
    if (iss_log.size() == 3) chk("raw2_gap", 32'(iss_log[2] - iss_log[1]), 32'd2);

    // Full queue: chained rd7 producers/consumers with in_valid held high
    apply_reset();
    saw_not_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 50) begin
        step(1'b1, mk(7, 7, 7, i, 8'h40 + i), 1'b0, acc);
        guard++;
      end
    end
    idle(30);
    chk("full_saw_not_ready", 32'(saw_not_ready), 32'h1);
    chk("full_issue_cnt", 32'(issue_cnt), 32'd8);

    // Flush with two entries queued behind a hazard
    apply_reset();
    push_ins(mk(0, 0, 9, 0, 8'h50));
    push_ins(mk(9, 0, 1, 0, 8'h51));
    push_ins(mk(2, 3, 4, 0, 8'h52));
    step(1'b0, '0, 1'b1, acc);
    chk("flush_in_ready_low", 32'(in_ready), 32'h0);
    idle(10);
    chk("flush_issue_cnt", 32'(issue_cnt), 32'd3);
    chk("flush_dd_pulses", 32'(dd_log.size()), 32'd1);
    if (dd_log.size() == 1 && iss_log.size() == 3)
      chk("flush_dd_gap", 32'(dd_log[0] - iss_log[2]), 32'(PIPE_DEPTH + 1));
    chk("flush_busy_end", 32'(busy), 32'h0);
    chk("flush_in_ready_end", 32'(in_ready), 32'h1);

    // Flush while idle and empty
    apply_reset();
    idle(2);
    f_edge = edge_no + 1;
    step(1'b0, '0, 1'b1, acc);
    idle(8);
    chk("idle_flush_pulses", 32'(dd_log.size()), 32'd1);
    if (dd_log.size() == 1) chk("idle_flush_latency", 32'(dd_log[0] - f_edge), 32'(PIPE_DEPTH + 1));

    // Reset during STALL with three entries queued
    apply_reset();
    push_ins(mk(0, 0, 9, 0, 8'h60));
    push_ins(mk(9, 1, 1, 0, 8'h61));
    push_ins(mk(2, 3, 4, 0, 8'h62));
    push_ins(mk(5, 6, 8, 0, 8'h63));
    chk("midrst_busy_before", 32'(busy), 32'h1);
    apply_reset();
    idle(6);
    chk("midrst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("midrst_n_issued", 32'(iss_log.size()), 32'd0);
    push_ins(mk(1, 1, 1, 1, 8'h70));
    idle(3);
    chk("postrst_n_issued", 32'(iss_log.size()), 32'd1);

    // Randomized traffic with narrow register ranges to provoke hazards
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0,
           mk($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 15), $urandom_range(0, 255)),
           $urandom_range(0, 40) == 0, acc);
    end
    idle(20);
    chk("rand_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
